// File: rtl/camera_pattern_gen_pkg.sv
// ----------------------------------------------------------------------------
// camera_gen_pkg
// Shared definitions for the camera test-pattern generator:
//   - mode_t  : test pattern selection encodings
//   - state_t : frame sequencer state encodings
//   - LFSR seed, tap mask and single-step helper
//   - checkerboard block shift (8x8 pixel blocks)
// ----------------------------------------------------------------------------
package camera_gen_pkg;

    typedef enum logic [1:0] {
        MODE_RAMP  = 2'd0,
        MODE_CONST = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_CHECK = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEAD   = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_HBLANK = 3'd3,
        ST_VBLANK = 3'd4
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: the feedback
    // bit is the XOR of register bits 0, 2, 3 and 5 and enters at bit 15.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Checker blocks are 2^CHECK_SHIFT pixels wide and tall.
    localparam int CHECK_SHIFT = 3;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/camera_pattern_gen_if.sv
// ----------------------------------------------------------------------------
// camera_pattern_gen_if
// CSI-style video stream bundle.
//   frame_valid : high for the whole frame (lead blanking through last pixel)
//   line_valid  : high for active pixels only
//   pixel_data  : pixel value, 0 whenever line_valid is low
// Stream semantics: there is no back-pressure. A pixel is transferred on
// every clock where line_valid is high; line_valid is only ever high while
// frame_valid is high. The source (master) drives, the sink (slave) samples.
// ----------------------------------------------------------------------------
interface camera_pattern_gen_if #(
    parameter int PIX_W = 10
);
    logic             frame_valid;
    logic             line_valid;
    logic [PIX_W-1:0] pixel_data;

    modport master (output frame_valid, line_valid, pixel_data);
    modport slave  (input  frame_valid, line_valid, pixel_data);
endinterface

// File: rtl/camera_pattern_gen_lfsr.sv
// ----------------------------------------------------------------------------
// pattern_lfsr
// 16-bit Fibonacci LFSR used by the pseudo-random test pattern.
//   clk, rst_n : clock, asynchronous active-low reset (register cleared to 0)
//   load       : reload LFSR_SEED (has priority over adv)
//   adv        : advance one step
//   value      : low OUT_W bits of the current register
// ----------------------------------------------------------------------------
module pattern_lfsr
    import camera_gen_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             adv,
    output logic [OUT_W-1:0] value
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'd0;
        end else if (load) begin
            lfsr_q <= LFSR_SEED;
        end else if (adv) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign value = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/camera_pattern_gen.sv
// ----------------------------------------------------------------------------
// camera_pattern_gen
// Test-pattern video source with configurable geometry and blanking.
// Frame: LEAD (H_BLANK) then HEIGHT x [ACTIVE (WIDTH)] separated by HBLANK
// (H_BLANK), then VBLANK (V_BLANK, frame_valid low, busy high).
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : start pulse, only looked at in IDLE
//   continuous  : restart after VBLANK, sampled on the last VBLANK cycle
//   mode        : 0 ramp, 1 constant, 2 LFSR, 3 checkerboard (latched at LEAD entry)
//   const_val   : constant-mode value (latched at LEAD entry)
//   vid         : frame_valid / line_valid / pixel_data stream (master)
//   busy        : high from first frame_valid cycle through last VBLANK cycle
//   frame_cnt   : completed frames, steps on the cycle frame_valid falls
//   dbg_state   : current sequencer state
// Optional build macro CAM_GEN_LINE_TAG_EN: pixel 0 of each line carries the
// line number instead of the pattern value (timing unchanged).
// All outputs are registered: they are computed from the next state.
// ----------------------------------------------------------------------------
module camera_pattern_gen
    import camera_gen_pkg::*;
#(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int PIX_W   = 10,
    parameter int H_BLANK = 16,
    parameter int V_BLANK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             continuous,
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] const_val,
    camera_pattern_gen_if.master vid,
    output logic             busy,
    output logic [15:0]      frame_cnt,
    output state_t           dbg_state
);

    localparam logic [15:0] W_LAST = 16'(WIDTH - 1);
    localparam logic [15:0] Y_LAST = 16'(HEIGHT - 1);
    localparam logic [15:0] H_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0] V_LAST = 16'(V_BLANK - 1);

    state_t           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;      // cycle index in state; x while ACTIVE
    logic [15:0]      y_q, y_d;
    logic             start;             // LEAD entry: latch config, reseed LFSR
    logic             frame_done;        // last pixel -> VBLANK
    mode_t            mode_q;
    logic [PIX_W-1:0] const_q;
    logic [PIX_W-1:0] base_q;            // frame_cnt at frame start (ramp offset)
    logic [PIX_W-1:0] lfsr_val;
    logic [PIX_W-1:0] pix_d;

    pattern_lfsr #(.OUT_W(PIX_W)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start),
        .adv   (state_d == ST_ACTIVE),   // advance after each pixel is issued
        .value (lfsr_val)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        y_d        = y_q;
        start      = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_LEAD;
                    cnt_d   = 16'd0;
                    start   = 1'b1;
                end
            end
            ST_LEAD: begin
                if (cnt_q == H_LAST) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = 16'd0;
                    y_d     = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_ACTIVE: begin
                if (cnt_q == W_LAST) begin
                    cnt_d = 16'd0;
                    if (y_q == Y_LAST) begin
                        state_d    = ST_VBLANK;
                        frame_done = 1'b1;
                    end else begin
                        state_d = ST_HBLANK;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_HBLANK: begin
                if (cnt_q == H_LAST) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = 16'd0;
                    y_d     = y_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_VBLANK: begin
                if (cnt_q == V_LAST) begin
                    cnt_d = 16'd0;
                    if (continuous) begin
                        state_d = ST_LEAD;
                        start   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // Pattern value for the pixel about to be presented (x = cnt_d, y = y_d).
    always_comb begin
        pix_d = '0;
        if (state_d == ST_ACTIVE) begin
            case (mode_q)
                MODE_RAMP:  pix_d = PIX_W'(cnt_d) + PIX_W'(y_d) + base_q;
                MODE_CONST: pix_d = const_q;
                MODE_LFSR:  pix_d = lfsr_val;
                MODE_CHECK: pix_d = (cnt_d[CHECK_SHIFT] ^ y_d[CHECK_SHIFT]) ? '1 : '0;
                default:    pix_d = '0;
            endcase
`ifdef CAM_GEN_LINE_TAG_EN
            if (cnt_d == 16'd0) begin
                pix_d = y_d[PIX_W-1:0];
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= 16'd0;
            y_q             <= 16'd0;
            mode_q          <= MODE_RAMP;
            const_q         <= '0;
            base_q          <= '0;
            frame_cnt       <= 16'd0;
            busy            <= 1'b0;
            vid.frame_valid <= 1'b0;
            vid.line_valid  <= 1'b0;
            vid.pixel_data  <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            y_q             <= y_d;
            busy            <= (state_d != ST_IDLE);
            vid.frame_valid <= (state_d == ST_LEAD) || (state_d == ST_ACTIVE) ||
                               (state_d == ST_HBLANK);
            vid.line_valid  <= (state_d == ST_ACTIVE);
            vid.pixel_data  <= pix_d;
            if (frame_done) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (start) begin
                mode_q  <= mode_t'(mode);
                const_q <= const_val;
                base_q  <= frame_cnt[PIX_W-1:0];
            end
        end
    end

    assign dbg_state = state_q;

endmodule
